// File: rtl/rtc_timekeeper.sv
// Real-time clock core: prescaler, one-second tick, validated time set and 12/24h display mapping.
// Optional alarm comparator enabled by defining RTC_ALARM_EN.
module rtc_timekeeper #(
  parameter int WIDTH     = 6,
  parameter int DIV_MAX   = 49999999,
  parameter int DIV_WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode_12h,
  input  logic             set_valid,
  input  logic [WIDTH-1:0] set_sec,
  input  logic [WIDTH-1:0] set_min,
  input  logic [WIDTH-1:0] set_hrs,
`ifdef RTC_ALARM_EN
  input  logic             alarm_arm,
  input  logic [WIDTH-1:0] alarm_min,
  input  logic [WIDTH-1:0] alarm_hrs,
  output logic             alarm_hit,
`endif
  output logic             set_err,
  output logic             tick_sec,
  output logic [WIDTH-1:0] count_sec,
  output logic [WIDTH-1:0] count_min,
  output logic [WIDTH-1:0] count_hrs,
  output logic             pm,
  output logic             clr_sec,
  output logic             clr_min,
  output logic             clr_day
);

  localparam logic [DIV_WIDTH-1:0] DIV_TC = DIV_WIDTH'(DIV_MAX);

  logic [DIV_WIDTH-1:0] div_q;
  logic [5:0]           sec_q, min_q, sec_nxt, min_nxt;
  logic [4:0]           hr_q, hr_nxt, hr12;
  logic                 set_ok, due, sec_wrap, min_wrap, day_wrap;

  // Full-width range check so out-of-range upper bits are rejected, not truncated.
  always_comb begin
    set_ok   = (set_sec <= WIDTH'(59)) && (set_min <= WIDTH'(59)) && (set_hrs <= WIDTH'(23));
    due      = (div_q == DIV_TC);
    sec_wrap = (sec_q == 6'd59);
    min_wrap = sec_wrap && (min_q == 6'd59);
    day_wrap = min_wrap && (hr_q == 5'd23);
    sec_nxt  = sec_wrap ? 6'd0 : sec_q + 6'd1;
    min_nxt  = !sec_wrap ? min_q : (min_wrap ? 6'd0 : min_q + 6'd1);
    hr_nxt   = !min_wrap ? hr_q : (day_wrap ? 5'd0 : hr_q + 5'd1);
  end

`ifdef RTC_ALARM_EN
  logic alarm_match;
  // Internal time is always in range, so out-of-range alarm values can never compare equal.
  assign alarm_match = alarm_arm && sec_wrap &&
                       (WIDTH'(min_nxt) == alarm_min) && (WIDTH'(hr_nxt) == alarm_hrs);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hr_q     <= '0;
      set_err  <= 1'b0;
      tick_sec <= 1'b0;
      clr_sec  <= 1'b0;
      clr_min  <= 1'b0;
      clr_day  <= 1'b0;
`ifdef RTC_ALARM_EN
      alarm_hit <= 1'b0;
`endif
    end else begin
      set_err  <= 1'b0;
      tick_sec <= 1'b0;
      clr_sec  <= 1'b0;
      clr_min  <= 1'b0;
      clr_day  <= 1'b0;
`ifdef RTC_ALARM_EN
      alarm_hit <= 1'b0;
`endif
      if (set_valid) begin
        // A set cycle never ticks; a rejected set also leaves the prescaler parked.
        if (set_ok) begin
          sec_q <= set_sec[5:0];
          min_q <= set_min[5:0];
          hr_q  <= set_hrs[4:0];
          div_q <= '0;
        end else begin
          set_err <= 1'b1;
        end
      end else if (en) begin
        if (due) begin
          div_q    <= '0;
          sec_q    <= sec_nxt;
          min_q    <= min_nxt;
          hr_q     <= hr_nxt;
          tick_sec <= 1'b1;
          clr_sec  <= sec_wrap;
          clr_min  <= min_wrap;
          clr_day  <= day_wrap;
`ifdef RTC_ALARM_EN
          alarm_hit <= alarm_match;
`endif
        end else begin
          div_q <= div_q + DIV_WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    if (hr_q == 5'd0)       hr12 = 5'd12;
    else if (hr_q > 5'd12)  hr12 = hr_q - 5'd12;
    else                    hr12 = hr_q;
  end

  assign count_sec = WIDTH'(sec_q);
  assign count_min = WIDTH'(min_q);
  assign count_hrs = WIDTH'(mode_12h ? hr12 : hr_q);
  assign pm        = (hr_q >= 5'd12);

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper with DIV_MAX=3; reference model tracks seconds-of-day.
module tb_rtc_timekeeper;
  localparam int W  = 6;
  localparam int DM = 3;

  logic         clk = 0, reset = 1, en = 0, mode_12h = 0, set_valid = 0;
  logic [W-1:0] set_sec = 0, set_min = 0, set_hrs = 0;
  logic         set_err, tick_sec, pm, clr_sec, clr_min, clr_day;
  logic [W-1:0] count_sec, count_min, count_hrs;
`ifdef RTC_ALARM_EN
  logic         alarm_arm = 0, alarm_hit;
  logic [W-1:0] alarm_min = 0, alarm_hrs = 0;
`endif

  rtc_timekeeper #(.WIDTH(W), .DIV_MAX(DM), .DIV_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode_12h(mode_12h), .set_valid(set_valid),
    .set_sec(set_sec), .set_min(set_min), .set_hrs(set_hrs),
`ifdef RTC_ALARM_EN
    .alarm_arm(alarm_arm), .alarm_min(alarm_min), .alarm_hrs(alarm_hrs), .alarm_hit(alarm_hit),
`endif
    .set_err(set_err), .tick_sec(tick_sec), .count_sec(count_sec), .count_min(count_min),
    .count_hrs(count_hrs), .pm(pm), .clr_sec(clr_sec), .clr_min(clr_min), .clr_day(clr_day)
  );

  always #5 clk = ~clk;

  // Reference state: seconds since midnight and prescaler count.
  int t = 0, p = 0;
  bit e_tick = 0, e_err = 0, e_cs = 0, e_cm = 0, e_cd = 0, e_hit = 0;
  int errors = 0, checks = 0;

  wire [23:0] dut_vec = {set_err, tick_sec, clr_sec, clr_min, clr_day, pm,
                         count_sec, count_min, count_hrs};

  function automatic logic [23:0] exp_vec();
    int h, dh;
    h  = t / 3600;
    dh = mode_12h ? ((h == 0) ? 12 : ((h > 12) ? h - 12 : h)) : h;
    return {e_err, e_tick, e_cs, e_cm, e_cd, logic'(h >= 12),
            6'(t % 60), 6'((t / 60) % 60), 6'(dh)};
  endfunction

  task automatic model_reset();
    t = 0; p = 0; e_tick = 0; e_err = 0; e_cs = 0; e_cm = 0; e_cd = 0; e_hit = 0;
  endtask

  // Advance model from current inputs, then let the DUT take the same edge.
  task automatic cycle();
    int nt = t, np = p;
    bit tk = 0, er = 0;
    if (set_valid) begin
      if (set_sec <= 59 && set_min <= 59 && set_hrs <= 23) begin
        nt = set_hrs * 3600 + set_min * 60 + set_sec; np = 0;
      end else er = 1;
    end else if (en) begin
      if (p == DM) begin np = 0; tk = 1; nt = (t + 1) % 86400; end
      else np = p + 1;
    end
    @(posedge clk); #1;
    t = nt; p = np; e_tick = tk; e_err = er;
    e_cs = tk && (nt % 60 == 0);
    e_cm = tk && (nt % 3600 == 0);
    e_cd = tk && (nt == 0);
`ifdef RTC_ALARM_EN
    e_hit = tk && (nt % 60 == 0) && alarm_arm &&
            (nt / 3600 == int'(alarm_hrs)) && ((nt / 60) % 60 == int'(alarm_min));
`endif
  endtask

  task automatic apply_set(input int s, input int m, input int h);
    set_sec = W'(s); set_min = W'(m); set_hrs = W'(h); set_valid = 1;
    cycle();
    set_valid = 0;
  endtask

  task automatic test_reset();
    checks++;
    if (dut_vec !== 24'h0) begin errors++; $display("FAIL reset_24h: got %h want %h", dut_vec, 24'h0); end
    mode_12h = 1; #1;
    checks++;
    if (count_hrs !== 6'd12) begin errors++; $display("FAIL reset_12h_hrs: got %0d want 12", count_hrs); end
    mode_12h = 0;
    reset = 0;
    model_reset();
  endtask

  task automatic test_tick();
    int ticks = 0;
    en = 1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      ticks += tick_sec;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL tick cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if (count_sec !== 6'd4 || ticks != 4) begin
      errors++; $display("FAIL tick_total: sec=%0d ticks=%0d want 4/4", count_sec, ticks);
    end
  endtask

  task automatic test_rollover();
    int days = 0;
    apply_set(58, 59, 23);
    checks++;
    if (dut_vec !== exp_vec() || pm !== 1'b1) begin errors++; $display("FAIL roll_set: got %h want %h", dut_vec, exp_vec()); end
    for (int i = 0; i < 8; i++) begin
      cycle();
      days += clr_day;
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL roll cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    checks++;
    if ({clr_sec, clr_min, clr_day, pm} !== 4'b1110 || days != 1 || count_hrs !== 0) begin
      errors++; $display("FAIL roll_day: clr=%b%b%b pm=%b days=%0d want 1110 1", clr_sec, clr_min, clr_day, pm, days);
    end
  endtask

  task automatic test_12h();
    mode_12h = 1;
    apply_set(0, 0, 0);
    checks++;
    if (count_hrs !== 6'd12 || pm !== 1'b0) begin errors++; $display("FAIL h12_midnight: hrs=%0d pm=%b want 12 0", count_hrs, pm); end
    apply_set(0, 5, 13);
    checks++;
    if (count_hrs !== 6'd1 || pm !== 1'b1) begin errors++; $display("FAIL h12_13: hrs=%0d pm=%b want 1 1", count_hrs, pm); end
    mode_12h = 0; #1;
    checks++;
    if (count_hrs !== 6'd13 || count_min !== 6'd5 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL h24_13: got %h want %h", dut_vec, exp_vec());
    end
    for (int h = 0; h < 24; h += 5) begin
      mode_12h = 1;
      apply_set(59, 59, h);
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL h12_map h%0d: got %h want %h", h, dut_vec, exp_vec()); end
    end
    mode_12h = 0;
  endtask

  task automatic test_set_err();
    int guard = 0;
    apply_set(10, 20, 3);
    en = 1;
    while (p != DM && guard < 8) begin cycle(); guard++; end
    checks++;
    if (p != DM) begin errors++; $display("FAIL err_wait: timed out p=%0d want %0d", p, DM); end
    set_sec = 60; set_min = 0; set_hrs = 0; set_valid = 1;
    cycle();
    set_valid = 0;
    checks++;
    if (set_err !== 1'b1 || tick_sec !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL err_sec60: got %h want %h", dut_vec, exp_vec());
    end
    cycle();
    checks++;
    if (set_err !== 1'b0 || tick_sec !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL err_after: got %h want %h", dut_vec, exp_vec());
    end
    apply_set(0, 0, 24);
    checks++;
    if (set_err !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL err_hrs24: got %h want %h", dut_vec, exp_vec()); end
    apply_set(0, 60, 0);
    checks++;
    if (set_err !== 1'b1 || dut_vec !== exp_vec()) begin errors++; $display("FAIL err_min60: got %h want %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_freeze();
    int guard = 0;
    en = 1;
    while (p != 1 && guard < 8) begin cycle(); guard++; end
    en = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec() || tick_sec !== 1'b0) begin errors++; $display("FAIL freeze cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    en = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL thaw cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    en = 0;
    apply_set(30, 20, 10);
    checks++;
    if (count_sec !== 6'd30 || count_min !== 6'd20 || count_hrs !== 6'd10) begin
      errors++; $display("FAIL set_en0: got %0d:%0d:%0d want 10:20:30", count_hrs, count_min, count_sec);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    en = 1;
    cycle();
    while (!e_tick && guard < 8) begin cycle(); guard++; end
    #2 reset = 1;
    #1;
    checks++;
    if (dut_vec !== 24'h0) begin errors++; $display("FAIL async_reset: got %h want %h", dut_vec, 24'h0); end
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 7) != 0);
      mode_12h  = $urandom_range(0, 1);
      set_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_sec = W'($urandom_range(55, 59)); set_min = 59; set_hrs = W'($urandom_range(11, 23));
      end else begin
        set_sec = W'($urandom_range(0, 63)); set_min = W'($urandom_range(0, 63)); set_hrs = W'($urandom_range(0, 31));
      end
      cycle();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random cyc%0d: got %h want %h", i, dut_vec, exp_vec()); end
    end
    set_valid = 0;
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm();
    int hits;
    alarm_min = 30; alarm_hrs = 7;
    for (int arm = 1; arm >= 0; arm--) begin
      alarm_arm = arm[0];
      en = 1; hits = 0;
      apply_set(58, 29, 7);
      for (int i = 0; i < 16; i++) begin
        cycle();
        hits += alarm_hit;
        checks++;
        if (alarm_hit !== e_hit) begin errors++; $display("FAIL alarm arm%0d cyc%0d: got %b want %b", arm, i, alarm_hit, e_hit); end
      end
      checks++;
      if (hits != arm) begin errors++; $display("FAIL alarm_count arm%0d: got %0d want %0d", arm, hits, arm); end
    end
    alarm_arm = 1;
    apply_set(0, 30, 7);
    checks++;
    if (alarm_hit !== 1'b0) begin errors++; $display("FAIL alarm_on_set: got %b want 0", alarm_hit); end
    alarm_min = 60;
    apply_set(58, 59, 7);
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (alarm_hit !== 1'b0) begin errors++; $display("FAIL alarm_oor cyc%0d: got %b want 0", i, alarm_hit); end
    end
    alarm_arm = 0;
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_tick();
    test_rollover();
    test_12h();
    test_set_err();
    test_freeze();
    test_async_reset();
    test_random();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
